// File: rtl/mod_reduce_seq.sv
// Sequential modular reducer: computes in_data mod M by folding CHUNK operand
// bits per cycle, MSB first, with valid/ready handshakes on both sides.
module mod_reduce_seq #(
  parameter int unsigned IN_W  = 32,
  parameter int unsigned M     = 997,
  parameter int unsigned RW    = 10,
  parameter int unsigned CHUNK = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [RW-1:0]   out_data,
  output logic            busy
);

  localparam int unsigned NCH  = (IN_W + CHUNK - 1) / CHUNK;
  localparam int unsigned SR_W = NCH * CHUNK;
  localparam int unsigned CW   = $clog2(NCH + 1);
  localparam int unsigned TW   = RW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [SR_W-1:0]   sr;
  logic [RW-1:0]     r;
  logic [CW-1:0]     cnt;
  logic [RW-1:0]     r_fold;
  logic [CHUNK-1:0]  chunk;
  logic [TW-1:0]     t;
  logic              accept_c;
  logic              last_c;

  // Reset dominates any handshake, so in_ready is masked while rst is high.
  assign in_ready = (state == IDLE) && !rst;
  assign out_data = r;
  assign accept_c = in_valid && (state == IDLE);
  // cnt reaching NCH marks the settle cycle after the final fold.
  assign last_c   = (cnt == CW'(NCH));

  // Horner fold of the top chunk of sr into the residue, one conditional subtract per bit.
  always_comb begin
    r_fold = r;
    chunk  = sr[SR_W-1 -: CHUNK];
    t      = '0;
    for (int i = 0; i < int'(CHUNK); i++) begin
      t = {r_fold, chunk[CHUNK-1]};
      if (t >= TW'(M)) begin
        t = t - TW'(M);
      end
      r_fold = t[RW-1:0];
      chunk  = chunk << 1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_c) state_nxt = RUN;
      RUN:     if (last_c) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr        <= '0;
      r         <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      out_valid <= (state_nxt == DONE);
      busy      <= (state_nxt != IDLE);
      case (state)
        IDLE: begin
          if (accept_c) begin
            sr  <= SR_W'(in_data);
            r   <= '0;
            cnt <= '0;
          end
        end
        RUN: begin
          if (!last_c) begin
            sr  <= sr << CHUNK;
            r   <= r_fold;
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_reduce_seq.sv
// Scoreboard bench for mod_reduce_seq: default instance (997/32/6) and a
// small instance (13/8/3) exercised exhaustively.
module tb_mod_reduce_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        iv0, ir0, ov0, or0, busy0;
  logic [31:0] id0;
  logic [9:0]  od0;
  logic        iv1, ir1, ov1, or1, busy1;
  logic [7:0]  id1;
  logic [3:0]  od1;

  mod_reduce_seq dut0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .in_data(id0),
    .out_valid(ov0), .out_ready(or0), .out_data(od0), .busy(busy0)
  );

  mod_reduce_seq #(.IN_W(8), .M(13), .RW(4), .CHUNK(3)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1), .busy(busy1)
  );

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;
  logic [9:0]  q0[$];
  logic [3:0]  q1[$];
  bit          stop_r;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: compare each delivered residue against the oldest expected one.
  always @(negedge clk) begin
    if (!rst && ov0 && or0) begin
      if (q0.size() == 0) check("res0_extra", 1, 0);
      else check("res0", 32'(od0), 32'(q0.pop_front()));
      check("rng0", 32'(od0 < 10'd997), 1);
    end
    if (!rst && ov1 && or1) begin
      if (q1.size() == 0) check("res1_extra", 1, 0);
      else check("res1", 32'(od1), 32'(q1.pop_front()));
      check("rng1", 32'(od1 < 4'd13), 1);
    end
  end

  task automatic send0(input logic [31:0] x, input logic [9:0] exp, input bit push);
    int n;
    n = 0;
    iv0 = 1'b1;
    id0 = x;
    do begin @(negedge clk); n++; end while (!ir0 && n < 200);
    if (!ir0) check("accept0_timeout", 0, 1);
    else if (push) q0.push_back(exp);
    @(posedge clk); #1;
    iv0 = 1'b0;
    id0 = $urandom;
  endtask

  task automatic send1(input logic [7:0] x, input bit push);
    int n;
    n = 0;
    iv1 = 1'b1;
    id1 = x;
    do begin @(negedge clk); n++; end while (!ir1 && n < 200);
    if (!ir1) check("accept1_timeout", 0, 1);
    else if (push) q1.push_back(4'(x % 8'd13));
    @(posedge clk); #1;
    iv1 = 1'b0;
    id1 = 8'($urandom);
  endtask

  // Counts edges from the accepting edge until out_valid is seen.
  task automatic lat0(input int unsigned exp_edges);
    int unsigned e;
    e = 0;
    @(negedge clk);
    while (!ov0 && e < 30) begin
      check("rdy_low0", 32'(ir0), 0);
      check("busy0", 32'(busy0), 1);
      @(posedge clk); e++;
      @(negedge clk);
    end
    check("lat0", e, exp_edges);
  endtask

  task automatic lat1(input int unsigned exp_edges);
    int unsigned e;
    e = 0;
    @(negedge clk);
    while (!ov1 && e < 30) begin
      check("rdy_low1", 32'(ir1), 0);
      @(posedge clk); e++;
      @(negedge clk);
    end
    check("lat1", e, exp_edges);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0]  held;
    logic [31:0] x;
    int          n;
    rst = 1'b1; iv0 = 1'b0; id0 = '0; or0 = 1'b1;
    iv1 = 1'b0; id1 = '0; or1 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(ir0), 0);
    check("rst_valid", 32'(ov0), 0);
    check("rst_busy", 32'(busy0), 0);
    check("rst_data", 32'(od0), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'(ir0), 1);

    // Directed boundary operands with latency and in_ready checks.
    @(posedge clk); #1;
    send0(32'd0, 10'd0, 1);     lat0(7);
    @(posedge clk); #1;
    send0(32'd997, 10'd0, 1);   lat0(7);
    @(posedge clk); #1;
    send0(32'd996, 10'd996, 1); lat0(7);
    @(posedge clk); #1;
    send0(32'hFFFF_FFFF, 10'd965, 1); lat0(7);
    @(posedge clk); #1;
    send0(32'd1_000_000, 10'd9, 1);   lat0(7);
    @(posedge clk); #1;
    x = 32'h8000_0000;
    send0(x, 10'(x % 32'd997), 1);    lat0(7);

    // Back-pressure: result held stable, in_valid pulses ignored.
    @(posedge clk); #1;
    or0 = 1'b0;
    send0(32'd54321, 10'(32'd54321 % 32'd997), 1);
    n = 0;
    do begin @(negedge clk); n++; end while (!ov0 && n < 30);
    check("bp_valid", 32'(ov0), 1);
    held = od0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      iv0 = ~iv0;
      id0 = $urandom;
      @(negedge clk);
      check("bp_data", 32'(od0), 32'(held));
      check("bp_valid_hold", 32'(ov0), 1);
      check("bp_ready", 32'(ir0), 0);
    end
    @(posedge clk); #1;
    iv0 = 1'b0;
    or0 = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_idle", 32'(ir0), 1);
    check("bp_valid_drop", 32'(ov0), 0);

    // Reset in the middle of a run discards the operand.
    @(posedge clk); #1;
    send0(32'd12345, 10'd0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mrst_ready", 32'(ir0), 1);
    check("mrst_valid", 32'(ov0), 0);
    check("mrst_busy", 32'(busy0), 0);
    repeat (10) @(negedge clk);
    check("mrst_no_out", 32'(ov0), 0);
    @(posedge clk); #1;
    send0(32'd12345, 10'd381, 1); lat0(7);

    // Random regression with input gaps and output stalls.
    @(posedge clk); #1;
    stop_r = 1'b0;
    fork
      begin
        for (int k = 0; k < 3000; k++) begin
          logic [31:0] rx;
          rx = $urandom;
          if (k % 4 == 0) rx = rx >> $urandom_range(0, 31);
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          send0(rx, 10'(rx % 32'd997), 1);
        end
        stop_r = 1'b1;
      end
      begin
        while (!stop_r) begin @(posedge clk); #1 or0 = 1'($urandom_range(0, 1)); end
      end
    join
    or0 = 1'b1;
    n = 0;
    while (q0.size() != 0 && n < 100) begin @(posedge clk); n++; end
    check("drain0", q0.size(), 0);

    // Small instance: latency, then exhaustive sweep with random stalls.
    @(posedge clk); #1;
    send1(8'd200, 1); lat1(4);
    @(posedge clk); #1;
    stop_r = 1'b0;
    fork
      begin
        for (int k = 0; k < 256; k++) send1(8'(k), 1);
        stop_r = 1'b1;
      end
      begin
        while (!stop_r) begin @(posedge clk); #1 or1 = 1'($urandom_range(0, 1)); end
      end
    join
    or1 = 1'b1;
    n = 0;
    while (q1.size() != 0 && n < 100) begin @(posedge clk); n++; end
    check("drain1", q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
